// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, FSM state encodings and the character lookup.
// Digits '0'..'9' are only encoded when MORSE_ENC_DIGITS_EN is defined.
package morse_pkg;

  localparam logic [1:0] SYM_DOT      = 2'b00;
  localparam logic [1:0] SYM_DASH     = 2'b01;
  localparam logic [1:0] SYM_CHAR_GAP = 2'b10;
  localparam logic [1:0] SYM_WORD_GAP = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef enum logic [1:0] {
    KIND_BAD    = 2'd0,
    KIND_LETTER = 2'd1,
    KIND_SPACE  = 2'd2
  } char_kind_e;

  // dash[i] describes element i (element 0 is sent first); 1 = DASH, 0 = DOT.
  typedef struct packed {
    char_kind_e  kind;
    logic [2:0]  len;
    logic [4:0]  dash;
  } char_code_t;

  function automatic char_code_t morse_lookup(input logic [7:0] ch);
    char_code_t c;
    logic [7:0] up;
    c      = '0;
    c.kind = KIND_BAD;
    up     = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    if (up == 8'h20) begin
      c.kind = KIND_SPACE;
    end else if (up >= 8'h41 && up <= 8'h5A) begin
      c.kind = KIND_LETTER;
      case (up)
        8'h41: {c.len, c.dash} = {3'd2, 5'b00010}; // A .-
        8'h42: {c.len, c.dash} = {3'd4, 5'b00001}; // B -...
        8'h43: {c.len, c.dash} = {3'd4, 5'b00101}; // C -.-.
        8'h44: {c.len, c.dash} = {3'd3, 5'b00001}; // D -..
        8'h45: {c.len, c.dash} = {3'd1, 5'b00000}; // E .
        8'h46: {c.len, c.dash} = {3'd4, 5'b00100}; // F ..-.
        8'h47: {c.len, c.dash} = {3'd3, 5'b00011}; // G --.
        8'h48: {c.len, c.dash} = {3'd4, 5'b00000}; // H ....
        8'h49: {c.len, c.dash} = {3'd2, 5'b00000}; // I ..
        8'h4A: {c.len, c.dash} = {3'd4, 5'b01110}; // J .---
        8'h4B: {c.len, c.dash} = {3'd3, 5'b00101}; // K -.-
        8'h4C: {c.len, c.dash} = {3'd4, 5'b00010}; // L .-..
        8'h4D: {c.len, c.dash} = {3'd2, 5'b00011}; // M --
        8'h4E: {c.len, c.dash} = {3'd2, 5'b00001}; // N -.
        8'h4F: {c.len, c.dash} = {3'd3, 5'b00111}; // O ---
        8'h50: {c.len, c.dash} = {3'd4, 5'b00110}; // P .--.
        8'h51: {c.len, c.dash} = {3'd4, 5'b01011}; // Q --.-
        8'h52: {c.len, c.dash} = {3'd3, 5'b00010}; // R .-.
        8'h53: {c.len, c.dash} = {3'd3, 5'b00000}; // S ...
        8'h54: {c.len, c.dash} = {3'd1, 5'b00001}; // T -
        8'h55: {c.len, c.dash} = {3'd3, 5'b00100}; // U ..-
        8'h56: {c.len, c.dash} = {3'd4, 5'b01000}; // V ...-
        8'h57: {c.len, c.dash} = {3'd3, 5'b00110}; // W .--
        8'h58: {c.len, c.dash} = {3'd4, 5'b01001}; // X -..-
        8'h59: {c.len, c.dash} = {3'd4, 5'b01101}; // Y -.--
        default: {c.len, c.dash} = {3'd4, 5'b00011}; // Z --..
      endcase
`ifdef MORSE_ENC_DIGITS_EN
    end else if (up >= 8'h30 && up <= 8'h39) begin
      c.kind = KIND_LETTER;
      c.len  = 3'd5;
      case (up)
        8'h30: c.dash = 5'b11111;
        8'h31: c.dash = 5'b11110;
        8'h32: c.dash = 5'b11100;
        8'h33: c.dash = 5'b11000;
        8'h34: c.dash = 5'b10000;
        8'h35: c.dash = 5'b00000;
        8'h36: c.dash = 5'b00001;
        8'h37: c.dash = 5'b00011;
        8'h38: c.dash = 5'b00111;
        default: c.dash = 5'b01111;
      endcase
`endif
    end
    return c;
  endfunction

endpackage

// File: rtl/morse_encoder_if.sv
// Character push channel between an upstream source and the encoder's character FIFO.
interface morse_encoder_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/morse_char_fifo.sv
// Character FIFO of QDEPTH entries (power of 2); no bypass, pointers wrap modulo QDEPTH.
module morse_char_fifo #(
  parameter int QDEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  morse_encoder_if.slave   push_if,
  input  logic             pop,
  output logic [7:0]       pop_data,
  output logic             not_empty
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          open_q, open_d;
  logic [7:0]    mem_q [QDEPTH];
  logic [7:0]    mem_d [QDEPTH];
  logic          push, do_pop;

  // open_q keeps the channel closed through reset and for the release edge itself.
  assign push_if.char_ready = open_q && (count_q != FULL_CNT);
  assign push      = push_if.char_valid && push_if.char_ready;
  assign do_pop    = pop && (count_q != '0);
  assign not_empty = (count_q != '0);
  assign pop_data  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    open_d   = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = push_if.char_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      open_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      open_q   <= open_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/morse_encoder.sv
// ASCII to Morse symbol encoder: character FIFO feeding an IDLE/LOAD/EMIT/GAP FSM.
// Define MORSE_ENC_DIGITS_EN to also encode '0'..'9'; otherwise digits are dropped with o_err.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_char_valid,
  input  logic [7:0] i_char,
  output logic       o_char_ready,
  output logic       o_sym_valid,
  output logic [1:0] o_sym,
  input  logic       i_sym_ready,
  output logic       o_busy,
  output logic       o_err
);

  morse_encoder_if char_if ();

  logic       pop, fifo_not_empty;
  logic [7:0] pop_data;

  assign char_if.char_valid = i_char_valid;
  assign char_if.char_data  = i_char;
  assign o_char_ready       = char_if.char_ready;

  morse_char_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push_if   (char_if),
    .pop       (pop),
    .pop_data  (pop_data),
    .not_empty (fifo_not_empty)
  );

  logic [1:0] state_q, state_d;
  char_code_t code_q, code_d;
  logic [2:0] idx_q, idx_d;
  logic       err_q, err_d;
  logic       sym_hs;

  // Symbol channel: o_sym_valid/o_sym decode from registered state only, so an offered
  // symbol stays put until the edge where o_sym_valid && i_sym_ready transfers it.
  assign o_sym_valid = (state_q == ST_EMIT) || (state_q == ST_GAP);
  assign sym_hs      = o_sym_valid && i_sym_ready;
  assign o_busy      = fifo_not_empty || (state_q != ST_IDLE);
  assign o_err       = err_q;

  always_comb begin
    o_sym = SYM_DOT;
    case (state_q)
      ST_EMIT: o_sym = code_q.dash[idx_q] ? SYM_DASH : SYM_DOT;
      ST_GAP:  o_sym = (code_q.kind == KIND_SPACE) ? SYM_WORD_GAP : SYM_CHAR_GAP;
      default: o_sym = SYM_DOT;
    endcase
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_not_empty) begin
          pop     = 1'b1;
          code_d  = morse_lookup(pop_data);
          err_d   = (code_d.kind == KIND_BAD);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        idx_d = '0;
        case (code_q.kind)
          KIND_LETTER: state_d = ST_EMIT;
          KIND_SPACE:  state_d = ST_GAP;
          default:     state_d = ST_IDLE;
        endcase
      end
      ST_EMIT: begin
        if (sym_hs) begin
          if (idx_q == code_q.len - 3'd1) begin
            state_d = ST_GAP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        if (sym_hs) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed self-checking bench for morse_encoder with a symbol scoreboard.
module tb_morse_encoder;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sym_ready;
  logic       sym_valid;
  logic [1:0] sym;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;
  int err_cnt  = 0;

  logic [1:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [1:0] prev_sym   = 2'b00;
  logic       prev_err   = 1'b0;

  morse_encoder_if cif ();

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  morse_encoder #(.QDEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_char_valid (cif.char_valid),
    .i_char       (cif.char_data),
    .o_char_ready (cif.char_ready),
    .o_sym_valid  (sym_valid),
    .o_sym        (sym),
    .i_sym_ready  (sym_ready),
    .o_busy       (busy),
    .o_err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, sym_valid}, 32'd1);
        check("hold_sym", {30'b0, sym}, {30'b0, prev_sym});
      end
      if (sym_valid && sym_ready) begin
        if (exp_q.size() == 0) check("extra_sym", {30'b0, sym}, 32'hFFFF_FFFF);
        else check("sym", {30'b0, sym}, {30'b0, exp_q.pop_front()});
      end
      if (err) err_cnt++;
      if (err && prev_err) check("err_width", 32'd2, 32'd1);
      prev_stall = sym_valid && !sym_ready;
      prev_sym   = sym;
      prev_err   = err;
    end else begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end
  end

  // driver tasks
  task automatic push_char(input logic [7:0] c);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    @(negedge clk);
    cif.char_valid = 1'b1;
    cif.char_data  = c;
    while (!acc && n < 300) begin
      acc = cif.char_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc) @(negedge clk);
    end
    cif.char_valid = 1'b0;
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_pattern(input int len, input logic [4:0] dash);
    for (int j = 0; j < len; j++) exp_q.push_back(dash[j] ? SYM_DASH : SYM_DOT);
    exp_q.push_back(SYM_CHAR_GAP);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!sym_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'b0, sym_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sym_valid"}, {31'b0, sym_valid}, 32'd0);
    check({tag, "_sym"}, {30'b0, sym}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_char_ready"}, {31'b0, cif.char_ready}, 32'd0);
  endtask

  logic [7:0] tv_ch   [5] = '{8'h51, 8'h7A, 8'h4A, 8'h54, 8'h58};
  int         tv_len  [5] = '{4, 4, 4, 1, 4};
  logic [4:0] tv_dash [5] = '{5'b01011, 5'b00011, 5'b01110, 5'b00001, 5'b01001};

  initial begin
    int acc;
    int err_base;
    cif.char_valid = 1'b0;
    cif.char_data  = 8'h00;
    sym_ready      = 1'b1;
    rst_n          = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ready_after_reset", {31'b0, cif.char_ready}, 32'd1);

    // 'S': latency of two edges, then four consecutive symbols
    exp_q.push_back(SYM_DOT); exp_q.push_back(SYM_DOT);
    exp_q.push_back(SYM_DOT); exp_q.push_back(SYM_CHAR_GAP);
    push_char(8'h53);
    @(negedge clk); check("lat_k0", {31'b0, sym_valid}, 32'd0);
    @(negedge clk); check("lat_k1", {31'b0, sym_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s_consecutive", {31'b0, sym_valid}, 32'd1);
    end
    wait_idle("s");

    // 'o' then space
    expect_pattern(3, 5'b00111);
    exp_q.push_back(SYM_WORD_GAP);
    push_char(8'h6F);
    push_char(8'h20);
    wait_idle("o_space");

    // 'A' stalled five cycles
    @(posedge clk); #1 sym_ready = 1'b0;
    expect_pattern(2, 5'b00010);
    push_char(8'h41);
    wait_valid("a");
    for (int i = 0; i < 5; i++) begin
      check("a_stall_valid", {31'b0, sym_valid}, 32'd1);
      check("a_stall_sym", {30'b0, sym}, {30'b0, SYM_DOT});
      @(negedge clk);
    end
    @(posedge clk); #1 sym_ready = 1'b1;
    wait_idle("a");

    // capacity: six offers of 'E' with the keyer stalled
    @(posedge clk); #1 sym_ready = 1'b0;
    acc = 0;
    @(negedge clk);
    cif.char_valid = 1'b1;
    cif.char_data  = 8'h45;
    for (int i = 0; i < 6; i++) begin
      if (cif.char_ready) acc++;
      @(negedge clk);
    end
    cif.char_valid = 1'b0;
    check("cap_accepted", acc, 32'd5);
    check("cap_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("cap_ready_low", {31'b0, cif.char_ready}, 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) expect_pattern(1, 5'b00000);
    @(posedge clk); #1 sym_ready = 1'b1;
    wait_idle("cap");

    // assorted letters, including lower case
    for (int i = 0; i < 5; i++) expect_pattern(tv_len[i], tv_dash[i]);
    for (int i = 0; i < 5; i++) push_char(tv_ch[i]);
    wait_idle("table");

    // unsupported '#', then 'E'
    err_base = err_cnt;
    push_char(8'h23);
    @(negedge clk); check("hash_err_early", {31'b0, err}, 32'd0);
    @(negedge clk); check("hash_err_pulse", {31'b0, err}, 32'd1);
    check("hash_no_sym", {31'b0, sym_valid}, 32'd0);
    @(negedge clk); check("hash_err_len", {31'b0, err}, 32'd0);
    check("hash_no_sym2", {31'b0, sym_valid}, 32'd0);
    expect_pattern(1, 5'b00000);
    push_char(8'h45);
    wait_idle("hash_e");
    check("hash_err_count", err_cnt - err_base, 32'd1);

    // digit '5'
    err_base = err_cnt;
`ifdef MORSE_ENC_DIGITS_EN
    expect_pattern(5, 5'b00000);
    push_char(8'h35);
    wait_idle("digit");
    check("digit_err_count", err_cnt - err_base, 32'd0);
`else
    push_char(8'h35);
    wait_idle("digit");
    check("digit_err_count", err_cnt - err_base, 32'd1);
`endif

    // reset in the middle of 'O' with 'M' queued
    exp_q.push_back(SYM_DASH);
    push_char(8'h4F);
    push_char(8'h4D);
    begin
      int n;
      n = 0;
      while (!(sym_valid && sym_ready) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("mid_first_dash", {31'b0, sym_valid && sym_ready}, 32'd1);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset");
    check("mid_reset_drained", exp_q.size(), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_ready_after", {31'b0, cif.char_ready}, 32'd1);
    check("mid_busy_after", {31'b0, busy}, 32'd0);
    check("mid_valid_after", {31'b0, sym_valid}, 32'd0);
    expect_pattern(1, 5'b00000);
    push_char(8'h45);
    wait_idle("mid_e");
    repeat (10) @(negedge clk);
    check("final_quiet", {31'b0, sym_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
